// File: rtl/simon_uart_sequencer.sv
// Block sequencer for SIMON-Said: Rx FIFO -> cipher core -> Tx FIFO.
// Edge-started, cipher handshake with timeout, Tx back-pressure and drain.
module simon_uart_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_BITS        = 11,
    parameter bit AUTO_START     = 1'b0
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       go,
    input  logic       mode_in,
    input  logic       rx_full,
    input  logic       tx_empty,
    input  logic       cipher_done,
    output logic       rx_read,
    output logic       cipher_start,
    output logic       cipher_mode,
    output logic       tx_write,
    output logic       busy,
    output logic       error,
    output logic [7:0] block_count,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_WRITE   = 3'd4,
        S_DRAIN   = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               go_q;
    logic               seen_busy;
    logic [TO_BITS-1:0] to_cnt;
    logic               go_rise;
    logic               start_cond;
    logic               to_hit;

    assign go_rise    = go & ~go_q;
    assign start_cond = rx_full & (AUTO_START ? 1'b1 : go_rise);
    assign to_hit     = (to_cnt == TO_LAST);
    assign state_out  = state;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            go_q         <= 1'b0;
            seen_busy    <= 1'b0;
            to_cnt       <= '0;
            rx_read      <= 1'b0;
            cipher_start <= 1'b0;
            cipher_mode  <= 1'b0;
            tx_write     <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            block_count  <= 8'd0;
        end else begin
            go_q         <= go;
            rx_read      <= 1'b0;
            cipher_start <= 1'b0;
            tx_write     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_cond) begin
                        state       <= S_CAPTURE;
                        cipher_mode <= mode_in;
                        rx_read     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state        <= S_START;
                    cipher_start <= 1'b1;
                end
                S_START: begin
                    state  <= S_WAIT;
                    to_cnt <= '0;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    // a result arriving on the last allowed cycle still counts
                    if (cipher_done) begin
                        state    <= S_WRITE;
                        tx_write <= tx_empty;
                    end else if (to_hit) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (tx_write) begin
                        state     <= S_DRAIN;
                        seen_busy <= 1'b0;
                    end else if (tx_empty) begin
                        tx_write <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!tx_empty) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        block_count <= block_count + 8'd1;
                    end
                end
                S_ERROR: begin
                    if (go_rise) begin
                        state <= S_IDLE;
                        error <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_uart_sequencer.sv
// Randomized bench for simon_uart_sequencer against a timeline model
// derived from the block's latency rules; three DUT configurations.
module tb_simon_uart_sequencer;

    localparam int T_SHORT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       go[3];
    logic       mode_in[3];
    logic       rx_full[3];
    logic       tx_empty[3];
    logic       cdone[3];
    logic       rx_read[3];
    logic       cstart[3];
    logic       cmode[3];
    logic       txw[3];
    logic       busy[3];
    logic       err[3];
    logic [7:0] bc[3];
    logic [2:0] st[3];

    int vectors = 0;
    int fails   = 0;
    int rr_auto = 0;
    int exp_bc[3];
    bit exp_mode[3];

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_read[2] === 1'b1) rr_auto++;

    simon_uart_sequencer #(
        .TIMEOUT_CYCLES(1024), .TO_BITS(11), .AUTO_START(1'b0)
    ) u_man (
        .clk_100MHz(clk), .reset(reset), .go(go[0]),
        .mode_in(mode_in[0]), .rx_full(rx_full[0]),
        .tx_empty(tx_empty[0]), .cipher_done(cdone[0]),
        .rx_read(rx_read[0]), .cipher_start(cstart[0]),
        .cipher_mode(cmode[0]), .tx_write(txw[0]), .busy(busy[0]),
        .error(err[0]), .block_count(bc[0]), .state_out(st[0])
    );

    simon_uart_sequencer #(
        .TIMEOUT_CYCLES(T_SHORT), .TO_BITS(11), .AUTO_START(1'b0)
    ) u_to (
        .clk_100MHz(clk), .reset(reset), .go(go[1]),
        .mode_in(mode_in[1]), .rx_full(rx_full[1]),
        .tx_empty(tx_empty[1]), .cipher_done(cdone[1]),
        .rx_read(rx_read[1]), .cipher_start(cstart[1]),
        .cipher_mode(cmode[1]), .tx_write(txw[1]), .busy(busy[1]),
        .error(err[1]), .block_count(bc[1]), .state_out(st[1])
    );

    simon_uart_sequencer #(
        .TIMEOUT_CYCLES(1024), .TO_BITS(11), .AUTO_START(1'b1)
    ) u_auto (
        .clk_100MHz(clk), .reset(reset), .go(go[2]),
        .mode_in(mode_in[2]), .rx_full(rx_full[2]),
        .tx_empty(tx_empty[2]), .cipher_done(cdone[2]),
        .rx_read(rx_read[2]), .cipher_start(cstart[2]),
        .cipher_mode(cmode[2]), .tx_write(txw[2]), .busy(busy[2]),
        .error(err[2]), .block_count(bc[2]), .state_out(st[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {rx_read, cipher_start, tx_write, busy, error, mode, state, count}
    function automatic logic [16:0] obs(input int i);
        return {rx_read[i], cstart[i], txw[i], busy[i], err[i],
                cmode[i], st[i], bc[i]};
    endfunction

    // One block from IDLE back to IDLE; step 0 is the current instant.
    task automatic run_block(input string tag, input int i, input int lat,
                             input int bp, input int dr, input bit mode);
        int d, w, fin, g;
        logic [2:0]  es;
        logic [16:0] ex;
        d   = 2 + lat;
        w   = d + 1 + bp;
        fin = w + dr + 1;
        g   = $urandom_range(1, 2);
        go[i]       = (i != 2);
        mode_in[i]  = mode;
        rx_full[i]  = 1'b1;
        cdone[i]    = 1'b0;
        tx_empty[i] = 1'($urandom);
        exp_mode[i] = mode;
        for (int s = 1; s <= fin; s++) begin
            step();
            if (s == fin) exp_bc[i] = (exp_bc[i] + 1) % 256;
            es = (s == 1) ? 3'd1 : (s == 2) ? 3'd2 : (s <= d) ? 3'd3 :
                 (s <= w) ? 3'd4 : (s < fin) ? 3'd5 : 3'd0;
            ex = {s == 1, s == 2, s == w, s < fin, 1'b0,
                  exp_mode[i], es, 8'(exp_bc[i])};
            vectors++;
            if (obs(i) !== ex) begin
                fails++;
                $display("FAIL %s inst%0d step%0d: got %05h want %05h",
                         tag, i, s, obs(i), ex);
            end
            go[i] = (i != 2) && ((s < g) ||
                    (s >= 3 && s < d && $urandom_range(0, 1) == 1));
            mode_in[i]  = 1'($urandom);
            rx_full[i]  = (i == 2 || s >= d) ? 1'b1 : 1'($urandom);
            cdone[i]    = (s == d) ||
                          (s > d && s < fin && $urandom_range(0, 3) == 0);
            tx_empty[i] = (s < d)      ? 1'($urandom) :
                          (s < d + bp) ? 1'b0 :
                          (s < w)      ? 1'b1 :
                          (s < w + dr) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go[i] = 0; mode_in[i] = 0; rx_full[i] = 0;
            tx_empty[i] = 1; cdone[i] = 0;
            exp_bc[i] = 0; exp_mode[i] = 0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== 17'h0) begin
                fails++;
                $display("FAIL reset inst%0d: got %05h want 00000",
                         i, obs(i));
            end
        end
        step();
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== 17'h0) begin
                fails++;
                $display("FAIL reset_release inst%0d: got %05h want 00000",
                         i, obs(i));
            end
        end
    endtask

    task automatic test_nominal();
        run_block("nominal", 0, 20, 0, $urandom_range(2, 6), 1'b0);
        for (int k = 0; k < 4; k++)
            run_block("nominal_rand", 0, $urandom_range(1, 40), 0,
                      $urandom_range(2, 8), 1'($urandom));
    endtask

    task automatic test_no_data();
        logic [16:0] ex;
        go[0] = 1'b1;
        rx_full[0] = 1'b0;
        for (int s = 1; s <= 9; s++) begin
            step();
            ex = {5'b0, exp_mode[0], 3'd0, 8'(exp_bc[0])};
            vectors++;
            if (obs(0) !== ex) begin
                fails++;
                $display("FAIL no_data step%0d: got %05h want %05h",
                         s, obs(0), ex);
            end
            go[0]       = (s < 8) ? 1'($urandom) : 1'b0;
            mode_in[0]  = 1'($urandom);
            tx_empty[0] = 1'($urandom);
            cdone[0]    = 1'($urandom);
        end
        cdone[0] = 1'b0;
    endtask

    task automatic test_back_pressure();
        run_block("backpressure50", 0, $urandom_range(1, 30), 50,
                  $urandom_range(2, 6), 1'($urandom));
        run_block("backpressure_rand", 0, $urandom_range(1, 30),
                  $urandom_range(1, 20), $urandom_range(2, 6), 1'($urandom));
    endtask

    task automatic test_done_tie();
        run_block("done_on_timeout", 1, T_SHORT, 0, 3, 1'b1);
        run_block("done_before_timeout", 1, T_SHORT - 1,
                  $urandom_range(0, 4), 2, 1'b0);
    endtask

    task automatic test_timeout();
        int e;
        bit m;
        logic [2:0]  es;
        logic [16:0] ex;
        e = $urandom_range(3, 6);
        m = 1'($urandom);
        go[1] = 1'b1; rx_full[1] = 1'b1; cdone[1] = 1'b0;
        mode_in[1] = m; exp_mode[1] = m;
        for (int s = 1; s <= T_SHORT + 2 + e; s++) begin
            step();
            es = (s == 1) ? 3'd1 : (s == 2) ? 3'd2 :
                 (s <= T_SHORT + 2) ? 3'd3 : 3'd6;
            ex = {s == 1, s == 2, 1'b0, s <= T_SHORT + 2, s > T_SHORT + 2,
                  exp_mode[1], es, 8'(exp_bc[1])};
            vectors++;
            if (obs(1) !== ex) begin
                fails++;
                $display("FAIL timeout step%0d: got %05h want %05h",
                         s, obs(1), ex);
            end
            go[1]       = 1'b0;
            rx_full[1]  = 1'($urandom);
            mode_in[1]  = 1'($urandom);
            tx_empty[1] = 1'($urandom);
            cdone[1]    = (s > T_SHORT + 2) ? 1'($urandom) : 1'b0;
        end
        go[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            ex = {5'b0, exp_mode[1], 3'd0, 8'(exp_bc[1])};
            vectors++;
            if (obs(1) !== ex) begin
                fails++;
                $display("FAIL error_clear step%0d: got %05h want %05h",
                         s, obs(1), ex);
            end
            go[1] = 1'b0;
            cdone[1] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int k;
        bit m;
        logic [2:0]  es;
        logic [16:0] ex;
        k = $urandom_range(4, 12);
        m = 1'($urandom);
        go[0] = 1'b1; rx_full[0] = 1'b1; tx_empty[0] = 1'b1;
        cdone[0] = 1'b0; mode_in[0] = m; exp_mode[0] = m;
        for (int s = 1; s <= k; s++) begin
            step();
            es = (s == 1) ? 3'd1 : (s == 2) ? 3'd2 : 3'd3;
            ex = {s == 1, s == 2, 1'b0, 1'b1, 1'b0,
                  exp_mode[0], es, 8'(exp_bc[0])};
            vectors++;
            if (obs(0) !== ex) begin
                fails++;
                $display("FAIL pre_reset step%0d: got %05h want %05h",
                         s, obs(0), ex);
            end
            go[0] = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_bc[i] = 0;
            exp_mode[i] = 0;
            vectors++;
            if (obs(i) !== 17'h0) begin
                fails++;
                $display("FAIL async_reset inst%0d: got %05h want 00000",
                         i, obs(i));
            end
        end
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (obs(0) !== 17'h0) begin
            fails++;
            $display("FAIL after_reset: got %05h want 00000", obs(0));
        end
        run_block("post_reset", 0, $urandom_range(1, 30), 0,
                  $urandom_range(2, 5), 1'($urandom));
    endtask

    task automatic test_auto_start();
        int rr0;
        logic [16:0] ex;
        rr0 = rr_auto;
        for (int b = 0; b < 256; b++)
            run_block("auto", 2, $urandom_range(1, 12),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                      $urandom_range(2, 4), 1'b1);
        rx_full[2] = 1'b0;
        step();
        ex = {5'b0, 1'b1, 3'd0, 8'd0};
        vectors++;
        if (obs(2) !== ex) begin
            fails++;
            $display("FAIL auto_wrap: got %05h want %05h", obs(2), ex);
        end
        vectors++;
        if (rr_auto - rr0 !== 256) begin
            fails++;
            $display("FAIL auto_rx_reads: got %0d want 256", rr_auto - rr0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_no_data();
        test_back_pressure();
        test_done_tie();
        test_timeout();
        test_async_reset();
        test_auto_start();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
